stream_dispatcher: RTL

STREAM_DISPATCHER -- requirements
Module: stream_dispatcher

---
 rtl/stream_dispatcher.sv | 117 +++++++++++
 1 files changed

// File: rtl/stream_dispatcher.sv
// Round-robin stream dispatcher: buffers up to two upstream words and offers each
// to one of NUMBER consumers through an external demux driven by sel/data_out.
module stream_dispatcher #(
  parameter  int WIDTH    = 1,
  parameter  int NUMBER   = 2,
  localparam int SELECT_W = $clog2(NUMBER)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic [WIDTH-1:0]    s_data,
  output logic [SELECT_W-1:0] sel,
  output logic [WIDTH-1:0]    data_out,
  output logic [NUMBER-1:0]   valid_out,
  input  logic [NUMBER-1:0]   ready_in,
  output logic [31:0]         dispatch_cnt
);

  typedef enum logic {IDLE, OFFER} state_t;

  state_t              state;
  logic [WIDTH-1:0]    mem [2];
  logic                rd_idx;
  logic                wr_idx;
  logic [1:0]          count;
  logic [SELECT_W-1:0] ptr;

  logic                push;
  logic                pop;
  logic [1:0]          count_next;
  logic                rd_next;
  logic [WIDTH-1:0]    head_next;
  logic [SELECT_W-1:0] ptr_next;
  logic [SELECT_W-1:0] choice;

  function automatic logic [SELECT_W-1:0] wrap_inc(input logic [SELECT_W-1:0] v);
    return (v == SELECT_W'(NUMBER - 1)) ? '0 : v + 1'b1;
  endfunction

  // First ready channel at or after p, wrapping; p itself when nobody is ready.
  function automatic logic [SELECT_W-1:0] choose(input logic [SELECT_W-1:0] p,
                                                 input logic [NUMBER-1:0]   rdy);
    logic [SELECT_W-1:0] c;
    logic [SELECT_W-1:0] res;
    logic                found;
    c     = p;
    res   = p;
    found = 1'b0;
    for (int i = 0; i < NUMBER; i++) begin
      if (!found && rdy[c]) begin
        res   = c;
        found = 1'b1;
      end
      c = wrap_inc(c);
    end
    return res;
  endfunction

  // NOTE: always_comb assigns every output first so no latch can be inferred.
  always_comb begin
    push       = s_valid && s_ready;
    pop        = (state == OFFER) && ready_in[sel];
    count_next = count + 2'(push) - 2'(pop);
    rd_next    = pop ? ~rd_idx : rd_idx;
    // A word written this edge into the slot that becomes head bypasses the array.
    head_next  = (push && (wr_idx == rd_next)) ? s_data : mem[rd_next];
    ptr_next   = pop ? wrap_inc(sel) : ptr;
    choice     = choose(ptr_next, ready_in);
  end

  // NOTE: storage array is not reset; occupancy and pointers alone define validity.
  always_ff @(posedge clk) begin
    if (push) mem[wr_idx] <= s_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      rd_idx       <= 1'b0;
      wr_idx       <= 1'b0;
      count        <= 2'd0;
      ptr          <= '0;
      sel          <= '0;
      data_out     <= '0;
      valid_out    <= '0;
      s_ready      <= 1'b0;
      dispatch_cnt <= '0;
    end else begin
      count   <= count_next;
      rd_idx  <= rd_next;
      ptr     <= ptr_next;
      s_ready <= (count_next != 2'd2);
      if (push) wr_idx <= ~wr_idx;
      if (pop) dispatch_cnt <= dispatch_cnt + 32'd1;

      if ((count_next != 2'd0) && ((state == IDLE) || pop)) begin
        state     <= OFFER;
        sel       <= choice;
        valid_out <= NUMBER'(1) << choice;
        data_out  <= head_next;
      end else if (pop) begin
        state     <= IDLE;
        valid_out <= '0;
      end
    end
  end

  a_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    (valid_out == '0) || (valid_out == (NUMBER'(1) << sel)));
  a_sel_range : assert property (@(posedge clk) disable iff (!rst_n)
    sel <= SELECT_W'(NUMBER - 1));
  a_count_range : assert property (@(posedge clk) disable iff (!rst_n)
    count <= 2'd2);

endmodule
